// File: rtl/simple_top_parity_pkg.sv
// Shared definitions for the SIMPLE_TOP parity checkers: lane count, lane parity and the
// sticky-error state encoding.
package simple_top_parity_pkg;

  // Widest lane any checker may use; narrower lanes are zero-extended, which does not
  // change their XOR reduction.
  localparam int unsigned MaxLaneW = 64;

  typedef enum logic {
    ErrClean   = 1'b0,
    ErrLatched = 1'b1
  } err_state_e;

  function automatic int unsigned lane_count(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  function automatic logic lane_parity(input logic [MaxLaneW-1:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/simple_top_parity_lane_chk.sv
// Combinational per-lane parity mismatch vector, with the lane-0 fault-inject flip.
// Shared with the read-channel checkers.
module simple_top_parity_lane_chk
  import simple_top_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LANE_W     = 8,
  parameter bit          ODD_PARITY = 1'b0,
  localparam int unsigned NL        = lane_count(DATA_W, LANE_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [NL-1:0]     parity_i,
  input  logic              fierr_i,
  output logic [NL-1:0]     mis_o
);

  logic [MaxLaneW-1:0] lane_ext;

  always_comb begin
    mis_o    = '0;
    lane_ext = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      lane_ext             = '0;
      lane_ext[LANE_W-1:0] = data_i[i*LANE_W +: LANE_W];
      mis_o[i]             = lane_parity(lane_ext, ODD_PARITY) ^ parity_i[i];
    end
    mis_o[0] = mis_o[0] ^ fierr_i;
  end

endmodule

// File: rtl/simple_top_parity_chk.sv
// Parity check stage in front of the SIMPLE_TOP write-data consumer: one-deep register slice
// plus error pulse, sticky dual-rail flag, first-error lane mask and saturating count.
module simple_top_parity_chk
  import simple_top_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LANE_W     = 8,
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned NL        = lane_count(DATA_W, LANE_W)
) (
  input  logic              ACLK,
  input  logic              RESET_ACLK,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [NL-1:0]     IN_PARITY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [NL-1:0]     OUT_PARITY,
  input  logic              ENERR,
  input  logic              FIERR,
  input  logic              ERR_CLR,
  output logic              ERR_PULSE,
  output logic              ERR,
  output logic              ERR_B,
  output logic [NL-1:0]     ERR_LANE,
  output logic [CNT_W-1:0]  ERR_CNT
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              accept;
  logic              err_beat;
  logic [NL-1:0]     mis;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [NL-1:0]     out_parity_q;

  err_state_e        err_state_q;
  logic              err_b_q;
  logic              err_pulse_q;
  logic [NL-1:0]     err_lane_q;
  logic [CNT_W-1:0]  err_cnt_q;

  assign IN_READY = !out_valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  simple_top_parity_lane_chk #(
    .DATA_W    (DATA_W),
    .LANE_W    (LANE_W),
    .ODD_PARITY(ODD_PARITY)
  ) u_lane_chk (
    .data_i  (IN_DATA),
    .parity_i(IN_PARITY),
    .fierr_i (FIERR),
    .mis_o   (mis)
  );

  assign err_beat = accept && (|mis) && ENERR;

  always_ff @(posedge ACLK) begin
    if (RESET_ACLK) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= IN_DATA;
      out_parity_q <= IN_PARITY;
    end else if (OUT_READY) begin
      out_valid_q  <= 1'b0;
    end
  end

  // ERR_B is its own flop rather than an inverter so the two rails fail independently.
  always_ff @(posedge ACLK) begin
    if (RESET_ACLK) begin
      err_state_q <= ErrClean;
      err_b_q     <= 1'b1;
      err_pulse_q <= 1'b0;
      err_lane_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_beat;
      unique case (err_state_q)
        ErrClean: begin
          if (err_beat) begin
            err_state_q <= ErrLatched;
            err_b_q     <= 1'b0;
            err_lane_q  <= mis;
          end
        end
        ErrLatched: begin
          // A clear coinciding with a new error restarts capture from that error.
          if (err_beat && ERR_CLR) begin
            err_lane_q  <= mis;
          end else if (ERR_CLR) begin
            err_state_q <= ErrClean;
            err_b_q     <= 1'b1;
            err_lane_q  <= '0;
          end
        end
      endcase
      if (err_beat) begin
        if (ERR_CLR) begin
          err_cnt_q <= CNT_W'(1);
        end else if (err_cnt_q != CntMax) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end else if (ERR_CLR) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;
  assign OUT_PARITY = out_parity_q;
  assign ERR_PULSE  = err_pulse_q;
  assign ERR        = (err_state_q == ErrLatched);
  assign ERR_B      = err_b_q;
  assign ERR_LANE   = err_lane_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: doc/simple_top_parity_chk.md
Name: simple_top_parity_chk

Overview:
- Registered check stage that sits directly upstream of the SIMPLE_TOP write-data consumer.
- Accepts a valid/ready beat carrying data plus per-lane parity and checks the parity on the accepted beat.
- Forwards the beat, with its parity unchanged, through a one-deep register slice.
- Reports errors as a pulse, a sticky dual-rail flag (ERR/ERR_B), a first-error lane mask and a saturating error count.
- Provides an error-report enable and a fault-injection input, so safety logic can exercise the error path.

Parameters:
- DATA_W, 64, data width; must be a multiple of LANE_W.
- LANE_W, 8, data bits covered by one parity bit. Number of lanes NL = DATA_W/LANE_W.
- ODD_PARITY, 0, 0 = even parity (XOR of lane bits and parity bit is 0); 1 = odd parity.
- CNT_W, 8, width of the error counter.

Ports:
- ACLK  in  1  clock.
- RESET_ACLK  in  1  synchronous, active-high reset.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  upstream beat accepted when IN_VALID && IN_READY.
- IN_DATA  in  DATA_W  beat data.
- IN_PARITY  in  NL  per-lane parity; bit i covers IN_DATA[i*LANE_W +: LANE_W].
- OUT_VALID  out  1  downstream valid.
- OUT_READY  in  1  downstream ready.
- OUT_DATA  out  DATA_W  registered data.
- OUT_PARITY  out  NL  registered parity, passed through unchanged.
- ENERR  in  1  error-report enable.
- FIERR  in  1  fault inject; flips the lane-0 check result on an accepted beat.
- ERR_CLR  in  1  clears ERR, ERR_LANE and ERR_CNT.
- ERR_PULSE  out  1  one-cycle pulse per erroneous accepted beat.
- ERR  out  1  sticky error flag.
- ERR_B  out  1  always ~ERR (dual-rail).
- ERR_LANE  out  NL  lane mask of the first error since the last clear.
- ERR_CNT  out  CNT_W  saturating count of erroneous beats.

Behaviour:
- Clocking and reset: one clock, ACLK. RESET_ACLK is synchronous and active-high.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_PARITY=0, ERR_PULSE=0, ERR=0, ERR_B=1, ERR_LANE=0, ERR_CNT=0.
- Reset mid-transfer drops the beat held in the slice; nothing is replayed.
- Register slice:
  - IN_READY = !OUT_VALID || OUT_READY (combinational, no bubble).
  - On accept: OUT_DATA/OUT_PARITY load next cycle and OUT_VALID=1. Latency is 1 cycle.
  - When OUT_VALID && OUT_READY with no new accept, OUT_VALID goes to 0.
  - Simultaneous drain and accept: the slice is replaced and OUT_VALID stays 1.
  - While stalled (OUT_VALID && !OUT_READY), OUT_DATA/OUT_PARITY are held stable.
- Check, evaluated on the accept cycle only:
  - mis[i] = (^lane_i) ^ IN_PARITY[i] ^ ODD_PARITY.
  - mis[0] is additionally XORed with FIERR.
  - Beats that are not accepted are never checked.
- Error beat: accept && |mis && ENERR.
  - ERR_PULSE=1 in the following cycle, aligned with the OUT_VALID rise for that beat.
- ERR state machine, two states:
  - CLEAN -> LATCHED on an error beat. ERR=1 and ERR_LANE=mis.
  - LATCHED -> CLEAN on ERR_CLR.
  - In LATCHED, further errors do not change ERR_LANE (first-error capture).
  - ERR_CLR and an error beat in the same cycle: the set wins. Next state is LATCHED, ERR_LANE = new mis, ERR_CNT=1.
- ERR_CNT:
  - Increments per error beat.
  - Saturates at 2^CNT_W-1 and never wraps.
  - ERR_CLR alone sets it to 0.
- ENERR=0: no pulse, no sticky state, no count. Data and parity still forward unchanged.
- Corrupt beats are never dropped or modified; reporting only.

Decomposition:
- Package simple_top_parity_pkg:
  - constant-function for lane count;
  - lane-parity function (XOR reduce plus ODD_PARITY);
  - ERR state encoding (CLEAN=1'b0, LATCHED=1'b1).
- Sub-module simple_top_parity_lane_chk: combinational NL-lane mismatch vector including the FIERR lane-0 flip. It is reused by other checkers on the read channels.
- Slice, sticky logic and counter stay in the top.

Test Plan (DATA_W=64, LANE_W=8, even, CNT_W=8 unless stated):
1. Accept 0x0000_0000_0000_0001 with IN_PARITY=0x01, ENERR=1, OUT_READY=1 -> OUT_VALID at cycle+1 with identical data and parity; ERR_PULSE=0, ERR=0, ERR_B=1.
2. Same data with IN_PARITY=0x00 -> ERR_PULSE=1 for one cycle at +1; ERR=1, ERR_B=0, ERR_LANE=0x01, ERR_CNT=1. A second bad beat on lane 3 -> ERR_CNT=2, ERR_LANE still 0x01.
3. Good beat with FIERR=1 -> ERR_LANE=0x01, ERR_CNT=1. Same beat with ENERR=0 -> no pulse, counter unchanged, data forwarded.
4. Backpressure: hold OUT_READY=0 with 3 beats offered -> IN_READY=0 after the first beat, OUT_DATA stable. Release OUT_READY -> beats emerge in order, one per cycle, with none lost or duplicated.
5. ERR_CLR asserted in the same cycle as an error beat -> ERR=1, ERR_CNT=1. ERR_CLR alone afterwards -> ERR=0, ERR_B=1, ERR_LANE=0, ERR_CNT=0.
6. CNT_W=2 with 5 consecutive error beats -> ERR_CNT=3 (saturates). RESET_ACLK=1 with a stalled beat -> next cycle OUT_VALID=0 and all error outputs at their reset values.
